cordic_vec_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one CORDIC vectoring core among up to N_REQ requesters (theta extraction, norm computation, Givens setup). It accepts (x, y) operand pairs over a valid/ready handshake and drives the core's reset, enable and operand inputs. It then collects the magnitude/angle result and returns it to the granted requester with a one-cycle response strobe. It sits between the FastICA control blocks and the single `CORDIC_Vectoring_top1` instance.

---
 rtl/cordic_vec_arbiter_if.sv | 28 ++
 rtl/cordic_vec_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_cordic_vec_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_vec_arbiter_if.sv
// Requester-side bundle of the CORDIC vectoring arbiter.
// master = requester side, slave = arbiter side.
interface cordic_vec_arbiter_if #(
   parameter int N_REQ       = 4,
   parameter int DATA_WIDTH  = 16,
   parameter int ANGLE_WIDTH = 16
);
   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0]            req_ready;
   logic [N_REQ*DATA_WIDTH-1:0] req_x_flat;
   logic [N_REQ*DATA_WIDTH-1:0] req_y_flat;
   logic [N_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]       rsp_xout;
   logic [ANGLE_WIDTH-1:0]      rsp_angle;
   logic                        rsp_timeout;

   modport master (
      output req_valid, req_x_flat, req_y_flat,
      input  req_ready, rsp_valid, rsp_xout,
      input  rsp_angle, rsp_timeout
   );

   modport slave (
      input  req_valid, req_x_flat, req_y_flat,
      output req_ready, rsp_valid, rsp_xout,
      output rsp_angle, rsp_timeout
   );
endinterface

// File: rtl/cordic_vec_arbiter.sv
// Round-robin sequencer sharing one CORDIC vectoring core.
// Define CORDIC_ARB_TIMEOUT_EN to enable the WAIT watchdog.
module cordic_vec_arbiter #(
   parameter int DATA_WIDTH     = 16,
   parameter int ANGLE_WIDTH    = 16,
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     nreset,
   cordic_vec_arbiter_if.slave      rif,
   output logic                     busy,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     core_nrst,
   output logic                     core_en,
   output logic [DATA_WIDTH-1:0]    core_xin,
   output logic [DATA_WIDTH-1:0]    core_yin,
   input  logic [DATA_WIDTH-1:0]    core_xout,
   input  logic [ANGLE_WIDTH-1:0]   core_angle,
   input  logic                     core_op_vld
);
   localparam int GW = $clog2(N_REQ);

   typedef enum logic [1:0] {
      IDLE, ISSUE, WAIT, RESP
   } state_t;

   state_t                 state_q, state_d;
   logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]          gid_q, gid_d;
   logic [GW-1:0]          sel_idx, idx;
   logic                   sel_found;
   logic [DATA_WIDTH-1:0]  opx_q, opx_d;
   logic [DATA_WIDTH-1:0]  opy_q, opy_d;
   logic [DATA_WIDTH-1:0]  xin_q, xin_d;
   logic [DATA_WIDTH-1:0]  yin_q, yin_d;
   logic [DATA_WIDTH-1:0]  rxout_q, rxout_d;
   logic [ANGLE_WIDTH-1:0] rang_q, rang_d;
   logic                   nrst_q, nrst_d;
   logic                   en_q, en_d;
   logic [N_REQ-1:0]       rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]  xs [N_REQ];
   logic [DATA_WIDTH-1:0]  ys [N_REQ];

`ifdef CORDIC_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rto_q, rto_d;
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
`endif

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         xs[i] = rif.req_x_flat[i*DATA_WIDTH +: DATA_WIDTH];
         ys[i] = rif.req_y_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // first valid requester at or after rr_ptr, wrapping
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      idx       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (int'(rr_ptr_q) + k >= N_REQ)
            idx = GW'(int'(rr_ptr_q) + k - N_REQ);
         else
            idx = GW'(int'(rr_ptr_q) + k);
         if (!sel_found && rif.req_valid[idx]) begin
            sel_found = 1'b1;
            sel_idx   = idx;
         end
      end
   end

   always_comb begin
      rif.req_ready = '0;
      if (nreset && state_q == IDLE && sel_found)
         rif.req_ready[sel_idx] = 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gid_d       = gid_q;
      opx_d       = opx_q;
      opy_d       = opy_q;
      nrst_d      = nrst_q;
      en_d        = en_q;
      xin_d       = xin_q;
      yin_d       = yin_q;
      rxout_d     = rxout_q;
      rang_d      = rang_q;
      rsp_valid_d = '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      rto_d       = rto_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (sel_found) begin
               opx_d   = xs[sel_idx];
               opy_d   = ys[sel_idx];
               gid_d   = sel_idx;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            nrst_d  = 1'b1;
            en_d    = 1'b1;
            xin_d   = opx_q;
            yin_d   = opy_q;
            state_d = WAIT;
`ifdef CORDIC_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT: begin
`ifdef CORDIC_ARB_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
            // a real result beats a watchdog expiring on the same edge
            if (core_op_vld) begin
               rxout_d = core_xout;
               rang_d  = core_angle;
               nrst_d  = 1'b0;
               en_d    = 1'b0;
               rsp_valid_d[gid_q] = 1'b1;
               state_d = RESP;
`ifdef CORDIC_ARB_TIMEOUT_EN
               rto_d   = 1'b0;
`endif
            end
`ifdef CORDIC_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               rxout_d = '0;
               rang_d  = '0;
               rto_d   = 1'b1;
               nrst_d  = 1'b0;
               en_d    = 1'b0;
               rsp_valid_d[gid_q] = 1'b1;
               state_d = RESP;
            end
`endif
         end
         RESP: begin
            if (gid_q == GW'(N_REQ - 1))
               rr_ptr_d = '0;
            else
               rr_ptr_d = gid_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         gid_q       <= '0;
         opx_q       <= '0;
         opy_q       <= '0;
         nrst_q      <= 1'b0;
         en_q        <= 1'b0;
         xin_q       <= '0;
         yin_q       <= '0;
         rxout_q     <= '0;
         rang_q      <= '0;
         rsp_valid_q <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
         cnt_q       <= '0;
         rto_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gid_q       <= gid_d;
         opx_q       <= opx_d;
         opy_q       <= opy_d;
         nrst_q      <= nrst_d;
         en_q        <= en_d;
         xin_q       <= xin_d;
         yin_q       <= yin_d;
         rxout_q     <= rxout_d;
         rang_q      <= rang_d;
         rsp_valid_q <= rsp_valid_d;
`ifdef CORDIC_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
         rto_q       <= rto_d;
`endif
      end
   end

   assign rif.rsp_valid = rsp_valid_q;
   assign rif.rsp_xout  = rxout_q;
   assign rif.rsp_angle = rang_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
   assign rif.rsp_timeout = rto_q;
`else
   assign rif.rsp_timeout = 1'b0;
`endif
   assign busy      = (state_q != IDLE);
   assign grant_id  = gid_q;
   assign core_nrst = nrst_q;
   assign core_en   = en_q;
   assign core_xin  = xin_q;
   assign core_yin  = yin_q;
endmodule

// File: tb/tb_cordic_vec_arbiter.sv
// Scoreboard bench for cordic_vec_arbiter with a latency-programmable core model.
// Timeout scenario runs when CORDIC_ARB_TIMEOUT_EN is defined.
module tb_cordic_vec_arbiter;
   localparam int DW = 16;
   localparam int AW = 16;
   localparam int N  = 4;
`ifdef CORDIC_ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 64;
`endif

   logic clk = 1'b0;
   logic nreset = 1'b0;
   always #5 clk = ~clk;

   cordic_vec_arbiter_if #(
      .N_REQ(N), .DATA_WIDTH(DW), .ANGLE_WIDTH(AW)
   ) rif ();

   logic          busy;
   logic [1:0]    grant_id;
   logic          core_nrst, core_en;
   logic [DW-1:0] core_xin, core_yin, core_xout;
   logic [AW-1:0] core_angle;
   logic          core_op_vld;

   cordic_vec_arbiter #(
      .DATA_WIDTH(DW), .ANGLE_WIDTH(AW),
      .N_REQ(N), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .nreset(nreset), .rif(rif),
      .busy(busy), .grant_id(grant_id),
      .core_nrst(core_nrst), .core_en(core_en),
      .core_xin(core_xin), .core_yin(core_yin),
      .core_xout(core_xout), .core_angle(core_angle),
      .core_op_vld(core_op_vld)
   );

   logic [N-1:0]  vld = '0;
   logic [DW-1:0] xv [N];
   logic [DW-1:0] yv [N];
   assign rif.req_valid = vld;
   always_comb begin
      rif.req_x_flat = '0;
      rif.req_y_flat = '0;
      for (int i = 0; i < N; i++) begin
         rif.req_x_flat[i*DW +: DW] = xv[i];
         rif.req_y_flat[i*DW +: DW] = yv[i];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // behavioural core: magnitude and a simple angle code
   function automatic logic [DW-1:0] mag(input logic [DW-1:0] x,
                                         input logic [DW-1:0] y);
      longint s, r, t;
      s = longint'(x) * longint'(x) + longint'(y) * longint'(y);
      r = 0;
      for (int b = 15; b >= 0; b--) begin
         t = r + (longint'(1) << b);
         if (t * t <= s) r = t;
      end
      return DW'(r);
   endfunction

   function automatic logic [AW-1:0] ang(input logic [DW-1:0] x,
                                         input logic [DW-1:0] y);
      return AW'(3 * int'(x) - int'(y));
   endfunction

   int   cur_lat = 18;
   int   next_lat = 18;
   bit   rand_mode = 0;
   int   ccnt = 0;
   logic core_vld_m = 1'b0;
   logic vld_inject = 1'b0;

   always @(posedge clk) begin
      if (!core_nrst || !core_en) begin
         ccnt       <= 0;
         core_vld_m <= 1'b0;
      end else begin
         ccnt       <= ccnt + 1;
         core_vld_m <= (cur_lat != 0 && ccnt + 1 == cur_lat);
      end
   end
   assign core_op_vld = core_vld_m | vld_inject;
   assign core_xout   = mag(core_xin, core_yin);
   assign core_angle  = ang(core_xin, core_yin);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int id;
      logic [DW-1:0] x;
      logic [DW-1:0] y;
      int lat;
      int acc;
   } exp_t;

   exp_t         sbq [$];
   int           grants [$];
   bit           model_idle = 1;
   int           mptr = 0;
   bit           prev_rsp = 0;
   logic [N-1:0] accepted = '0;
   logic [N-1:0] done = '0;

   // reference round-robin choice plus response scoreboard
   always @(negedge clk) begin
      logic [N-1:0] er;
      int   id, j, elat;
      bit   f, to;
      exp_t e;
      if (!nreset) begin
         model_idle = 1;
         mptr       = 0;
         prev_rsp   = 0;
         sbq.delete();
      end else begin
         er = '0;
         f  = 0;
         if (model_idle) begin
            for (int k = 0; k < N; k++) begin
               j = (mptr + k) % N;
               if (!f && rif.req_valid[j]) begin
                  er[j] = 1'b1;
                  f = 1;
               end
            end
         end
         chk("req_ready", rif.req_ready, er);
         chk("busy", busy, !model_idle);
         if (|(rif.req_valid & rif.req_ready)) begin
            id = 0;
            for (int k = 0; k < N; k++)
               if (rif.req_ready[k]) id = k;
            cur_lat = rand_mode ? $urandom_range(1, 20) : next_lat;
            e.id  = id;
            e.x   = xv[id];
            e.y   = yv[id];
            e.lat = cur_lat;
            e.acc = cyc;
            sbq.push_back(e);
            grants.push_back(id);
            accepted[id] = 1'b1;
            model_idle = 0;
         end
         if (|rif.rsp_valid) begin
            chk("rsp_one_cycle", prev_rsp, 0);
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got %0h expected none",
                        rif.rsp_valid);
            end else begin
               e    = sbq.pop_front();
               to   = (e.lat == 0);
               elat = to ? TO + 2 : e.lat + 3;
               chk("rsp_valid", rif.rsp_valid, N'(1) << e.id);
               chk("rsp_xout", rif.rsp_xout, to ? '0 : mag(e.x, e.y));
               chk("rsp_angle", rif.rsp_angle, to ? '0 : ang(e.x, e.y));
               chk("rsp_timeout", rif.rsp_timeout, to);
               chk("latency", cyc - e.acc, elat);
               mptr = (e.id + 1) % N;
               done[e.id] = 1'b1;
               model_idle = 1;
            end
         end
         prev_rsp = |rif.rsp_valid;
      end
   end

   task automatic wait_acc(input int r);
      int k = 0;
      while (!accepted[r] && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      chk($sformatf("accept%0d", r), accepted[r], 1);
   endtask

   task automatic wait_done(input int r);
      int k = 0;
      while (!done[r] && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      chk($sformatf("done%0d", r), done[r], 1);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (!(model_idle && sbq.size() == 0) && k < 600) begin
         @(posedge clk); #1;
         k++;
      end
      chk("drain", model_idle && sbq.size() == 0, 1);
   endtask

   task automatic drive(input int r);
      int k, hold;
      bit ab;
      repeat (6) begin
         repeat ($urandom_range(0, 4)) @(posedge clk);
         @(posedge clk); #1;
         xv[r] = DW'($urandom_range(0, 16'h3FFF));
         yv[r] = DW'($urandom_range(0, 16'h3FFF));
         accepted[r] = 1'b0;
         done[r] = 1'b0;
         vld[r] = 1'b1;
         ab   = ($urandom_range(0, 3) == 0);
         hold = $urandom_range(1, 3);
         k = 0;
         while (!accepted[r] && k < 400 && !(ab && k >= hold)) begin
            @(posedge clk); #1;
            k++;
         end
         vld[r] = 1'b0;
         if (accepted[r]) begin
            k = 0;
            while (!done[r] && k < 400) begin
               @(posedge clk); #1;
               k++;
            end
            chk($sformatf("rand_done%0d", r), done[r], 1);
         end else if (!ab) begin
            chk($sformatf("rand_acc%0d", r), accepted[r], 1);
         end
      end
   endtask

   initial begin
      int k;
      int eo [5];
      eo = '{0, 1, 2, 3, 0};
      for (int i = 0; i < N; i++) begin
         xv[i] = DW'($urandom_range(0, 16'h3FFF));
         yv[i] = DW'($urandom_range(0, 16'h3FFF));
      end
      next_lat = 5;
      vld = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", rif.req_ready, 0);
      chk("rst_rsp_valid", rif.rsp_valid, 0);
      chk("rst_rsp_xout", rif.rsp_xout, 0);
      chk("rst_rsp_angle", rif.rsp_angle, 0);
      chk("rst_rsp_timeout", rif.rsp_timeout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_core_nrst", core_nrst, 0);
      chk("rst_core_en", core_en, 0);
      chk("rst_core_xin", core_xin, 0);
      chk("rst_core_yin", core_yin, 0);

      // all four requesters held valid straight out of reset
      @(posedge clk); #1;
      nreset = 1'b1;
      k = 0;
      while (grants.size() < 5 && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      vld = '0;
      chk("all4_count", grants.size() >= 5, 1);
      if (grants.size() >= 5)
         for (int i = 0; i < 5; i++)
            chk($sformatf("all4_order%0d", i), grants[i], eo[i]);
      wait_idle();

      // single request, core latency 18
      next_lat = 18;
      xv[0] = 16'h0300;
      yv[0] = 16'h0400;
      accepted = '0;
      done = '0;
      @(posedge clk); #1;
      vld[0] = 1'b1;
      wait_acc(0);
      vld[0] = 1'b0;
      @(negedge clk);
      chk("a1_core_en", core_en, 0);
      @(negedge clk);
      chk("a2_core_xin", core_xin, 16'h0300);
      chk("a2_core_yin", core_yin, 16'h0400);
      chk("a2_core_en", core_en, 1);
      chk("a2_core_nrst", core_nrst, 1);
      wait_done(0);
      chk("single_xout", rif.rsp_xout, 16'h0500);
      wait_idle();

      // reset pulse while the core is busy
      accepted = '0;
      done = '0;
      xv[3] = 16'h0123;
      yv[3] = 16'h0456;
      @(posedge clk); #1;
      vld[3] = 1'b1;
      wait_acc(3);
      vld[3] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      nreset = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_core_nrst", core_nrst, 0);
      chk("mid_rst_core_en", core_en, 0);
      chk("mid_rst_core_xin", core_xin, 0);
      chk("mid_rst_grant_id", grant_id, 0);
      chk("mid_rst_rsp_valid", rif.rsp_valid, 0);
      @(posedge clk); #1;
      nreset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_rst_no_rsp", done[3], 0);

      // fresh request after reset starts from index 0
      grants.delete();
      accepted = '0;
      done = '0;
      vld = 4'b0101;
      wait_acc(0);
      vld = '0;
      wait_idle();
      chk("fresh_count", grants.size(), 1);
      if (grants.size() >= 1)
         chk("fresh_grant", grants[0], 0);

      // requester 2 withdraws before its turn
      grants.delete();
      accepted = '0;
      done = '0;
      @(posedge clk); #1;
      vld = 4'b1110;
      wait_acc(1);
      vld[1] = 1'b0;
      vld[2] = 1'b0;
      wait_acc(3);
      vld[3] = 1'b0;
      wait_idle();
      chk("drop_count", grants.size(), 2);
      if (grants.size() >= 2) begin
         chk("drop_first", grants[0], 1);
         chk("drop_second", grants[1], 3);
      end
      chk("drop_no_rsp2", done[2], 0);

      // stray core valid while idle
      @(posedge clk); #1;
      vld_inject = 1'b1;
      @(posedge clk); #1;
      vld_inject = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_vld_busy", busy, 0);
      chk("idle_vld_rsp", rif.rsp_valid, 0);

`ifdef CORDIC_ARB_TIMEOUT_EN
      next_lat = 0;
      accepted = '0;
      done = '0;
      @(posedge clk); #1;
      vld[1] = 1'b1;
      wait_acc(1);
      vld[1] = 1'b0;
      wait_done(1);
      chk("tmo_flag", rif.rsp_timeout, 1);
      wait_idle();
      next_lat = 6;
      @(posedge clk); #1;
      vld[2] = 1'b1;
      wait_acc(2);
      vld[2] = 1'b0;
      wait_done(2);
      chk("tmo_clear", rif.rsp_timeout, 0);
      wait_idle();
`endif

      // randomized contention
      rand_mode = 1;
      for (int i = 0; i < N; i++) begin
         fork
            automatic int r = i;
            drive(r);
         join_none
      end
      wait fork;
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule
